// File: rtl/crc64_pkg.sv
// crc64_pkg: shared constants and state type for the CRC-64 link agent
package crc64_pkg;

   localparam logic [63:0] CRC64_POLY    = 64'h42F0E1EBA9EA3693;
   localparam int          FRAME_BYTES   = 15;
   localparam int          PAYLOAD_BYTES = 7;
   localparam logic [7:0]  STATUS_OK     = 8'h00;

   typedef enum logic [1:0] {
      IDLE,
      TX,
      RX,
      RESULT
   } state_t;

endpackage

// File: rtl/crc64_byte_update.sv
// crc64_byte_update: one byte of CRC-64/ECMA-182, MSB-first, no reflection
module crc64_byte_update
   import crc64_pkg::*;
(
   input  logic [63:0] crc_in,
   input  logic [7:0]  byte_in,
   output logic [63:0] crc_out
);

   logic [63:0] c;

   // eight unrolled shift/xor steps with the byte folded into the top bits
   always_comb begin
      c = crc_in ^ {byte_in, 56'h0};
      for (int i = 0; i < 8; i++)
         c = c[63] ? ({c[62:0], 1'b0} ^ CRC64_POLY) : {c[62:0], 1'b0};
      crc_out = c;
   end

endmodule

// File: rtl/crc64_link_agent.sv
// crc64_link_agent: sends a command frame with CRC-64 and checks the response frame
module crc64_link_agent
   import crc64_pkg::*;
#(
   parameter int         TIMEOUT_CYCLES = 1024,
   parameter logic [7:0] HEADER_BYTE    = 8'h11
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        valid_a,
   input  logic [55:0] data_a,
   input  logic        select_signal,
   output logic        tx_valid,
   output logic [7:0]  tx_data,
   input  logic        tx_ready,
   input  logic        rx_valid,
   input  logic [7:0]  rx_data,
   output logic        o_pass,
   output logic        o_fail,
   output logic        o_false,
   output logic        busy
);

   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   state_t        state, state_nxt;
   logic          prev_valid;
   logic          accept;
   logic          hs;
   logic          last_byte;
   logic          payload_phase;
   logic          timeout_hit;
   logic          bad;
   logic          hdr_bad;
   logic          to_flag;
   logic [55:0]   data_r;
   logic [63:0]   crc, crc_next;
   logic [7:0]    crc_byte;
   logic [7:0]    status;
   logic [3:0]    cnt;
   logic [TW-1:0] timer, timer_inc;

   assign accept        = (state == IDLE) && valid_a && !prev_valid && !select_signal;
   assign hs            = tx_valid && tx_ready;
   assign last_byte     = cnt == 4'(FRAME_BYTES - 1);
   assign payload_phase = cnt < 4'(PAYLOAD_BYTES);
   assign timer_inc     = timer + TW'(1);
   assign timeout_hit   = !rx_valid && (timer_inc == TW'(TIMEOUT_CYCLES));
   // the single CRC engine sees the outgoing payload byte in TX and the incoming byte otherwise
   assign crc_byte      = (state == TX) ? data_r[55:48] : rx_data;

   crc64_byte_update u_crc (
      .crc_in (crc),
      .byte_in(crc_byte),
      .crc_out(crc_next)
   );

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    state_nxt = accept ? TX : IDLE;
         TX:      state_nxt = (hs && last_byte) ? RX : TX;
         RX:      state_nxt = ((rx_valid && last_byte) || timeout_hit) ? RESULT : RX;
         RESULT:  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // datapath: command latch, CRC accumulation/shift-out, byte counter, timer and response flags
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prev_valid <= 1'b0;
         data_r     <= '0;
         crc        <= '0;
         cnt        <= '0;
         timer      <= '0;
         hdr_bad    <= 1'b0;
         to_flag    <= 1'b0;
         status     <= '0;
      end else begin
         prev_valid <= valid_a;
         if (accept) begin
            data_r  <= data_a;
            crc     <= '0;
            cnt     <= '0;
            timer   <= '0;
            hdr_bad <= 1'b0;
            to_flag <= 1'b0;
            status  <= '0;
         end else if (state == TX && hs) begin
            cnt   <= last_byte ? 4'd0 : cnt + 4'd1;
            timer <= '0;
            if (payload_phase) begin
               data_r <= data_r << 8;
               crc    <= crc_next;
            end else begin
               crc <= last_byte ? 64'h0 : crc << 8;
            end
         end else if (state == RX) begin
            if (rx_valid) begin
               crc   <= crc_next;
               cnt   <= cnt + 4'd1;
               timer <= '0;
               if (cnt == 4'd0)
                  hdr_bad <= rx_data != HEADER_BYTE;
               if (cnt == 4'd1)
                  status <= rx_data;
            end else begin
               timer <= timer_inc;
               if (timeout_hit)
                  to_flag <= 1'b1;
            end
         end
      end
   end

   // outputs: TX byte mux and the one-hot verdict during RESULT
   always_comb begin
      busy     = state != IDLE;
      tx_valid = state == TX;
      tx_data  = !tx_valid ? 8'h00 : payload_phase ? data_r[55:48] : crc[63:56];
      bad      = to_flag || (crc != 64'h0) || hdr_bad;
      o_false  = (state == RESULT) && bad;
      o_fail   = (state == RESULT) && !bad && (status != STATUS_OK);
      o_pass   = (state == RESULT) && !bad && (status == STATUS_OK);
   end

endmodule

// File: tb/tb_crc64_link_agent.sv
// tb_crc64_link_agent: scoreboard bench for the CRC-64 link agent
module tb_crc64_link_agent;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        valid_a = 1'b0;
   logic [55:0] data_a = '0;
   logic        select_signal = 1'b0;
   logic        tx_valid;
   logic [7:0]  tx_data;
   logic        tx_ready = 1'b1;
   logic        rx_valid = 1'b0;
   logic [7:0]  rx_data = '0;
   logic        o_pass, o_fail, o_false, busy;

   logic [63:0] u_in, u_out;
   logic [7:0]  u_byte;

   int          n_tests = 0;
   int          n_fail = 0;
   int          cyc = 0;
   int          res_cnt = 0;
   int          last_res_cyc = 0;
   int          last_rx_edge = 0;
   int          acc_edge = 0;
   int          hs_edges[$];
   logic [7:0]  tx_q[$];
   logic [2:0]  res_q[$];
   logic [7:0]  rsp[15];
   logic        stall_prev = 1'b0;
   logic [7:0]  held = '0;

   crc64_link_agent #(.TIMEOUT_CYCLES(16), .HEADER_BYTE(8'h11)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .valid_a      (valid_a),
      .data_a       (data_a),
      .select_signal(select_signal),
      .tx_valid     (tx_valid),
      .tx_data      (tx_data),
      .tx_ready     (tx_ready),
      .rx_valid     (rx_valid),
      .rx_data      (rx_data),
      .o_pass       (o_pass),
      .o_fail       (o_fail),
      .o_false      (o_false),
      .busy         (busy)
   );

   crc64_byte_update u_unit (
      .crc_in (u_in),
      .byte_in(u_byte),
      .crc_out(u_out)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // bit-serial reference CRC-64/ECMA-182
   function automatic logic [63:0] model_crc(input logic [63:0] c, input logic [7:0] b);
      logic [63:0] r = c;
      for (int i = 7; i >= 0; i--) begin
         logic fb = r[63] ^ b[i];
         r = r << 1;
         if (fb) r = r ^ 64'h42F0E1EBA9EA3693;
      end
      return r;
   endfunction

   // TX scoreboard: every handshake pops one expected byte
   always @(negedge clk) begin
      if (tx_valid && tx_ready) begin
         hs_edges.push_back(cyc + 1);
         if (tx_q.size() == 0) check("tx_unexpected", 1, 0);
         else check("tx_byte", tx_data, tx_q.pop_front());
      end
   end

   // stall monitor: the presented byte must hold while the sink is not ready
   always @(negedge clk) begin
      if (stall_prev && tx_valid) check("tx_stable", tx_data, held);
      stall_prev <= rst_n && tx_valid && !tx_ready;
      held <= tx_data;
   end

   // result scoreboard
   always @(negedge clk) begin
      if (o_pass || o_fail || o_false) begin
         res_cnt <= res_cnt + 1;
         last_res_cyc <= cyc;
         check("res_onehot", $countones({o_pass, o_fail, o_false}), 1);
         if (res_q.size() == 0) check("res_unexpected", 1, 0);
         else check("res_code", {o_pass, o_fail, o_false}, res_q.pop_front());
      end
   end

   task automatic send_cmd(input logic [55:0] d, input int hold);
      logic [63:0] c = '0;
      for (int i = 0; i < 7; i++) begin
         tx_q.push_back(d[55-8*i -: 8]);
         c = model_crc(c, d[55-8*i -: 8]);
      end
      for (int i = 0; i < 8; i++) tx_q.push_back(c[63-8*i -: 8]);
      @(posedge clk) #1;
      valid_a = 1'b1;
      data_a = d;
      acc_edge = cyc + 1;
      for (int i = 1; i < hold; i++) @(posedge clk) #1;
      if (hold > 0) valid_a = 1'b0;
   endtask

   task automatic wait_rx();
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(busy && !tx_valid) && n < 200);
      if (n >= 200) check("rx_wait_expired", 0, 1);
   endtask

   task automatic make_rsp(input logic [7:0] hdr, input logic [7:0] st, input bit corrupt);
      logic [63:0] c = '0;
      rsp[0] = hdr;
      rsp[1] = st;
      for (int i = 2; i < 7; i++) rsp[i] = 8'(8'h20 + i);
      for (int i = 0; i < 7; i++) c = model_crc(c, rsp[i]);
      for (int i = 0; i < 8; i++) rsp[7+i] = c[63-8*i -: 8];
      if (corrupt) rsp[14] = ~rsp[14];
   endtask

   task automatic send_rsp(input int nb);
      for (int i = 0; i < nb; i++) begin
         @(posedge clk) #1;
         rx_valid = 1'b1;
         rx_data = rsp[i];
         last_rx_edge = cyc + 1;
      end
      @(posedge clk) #1;
      rx_valid = 1'b0;
   endtask

   task automatic wait_res(input int budget);
      int start = res_cnt;
      int n = 0;
      while (res_cnt == start && n < budget) begin
         @(negedge clk) #1;
         n++;
      end
      if (res_cnt == start) check("res_wait_expired", 0, 1);
   endtask

   task automatic run_frame(input logic [55:0] d, input logic [7:0] hdr, input logic [7:0] st,
                            input bit corrupt, input logic [2:0] code, input string tag);
      res_q.push_back(code);
      send_cmd(d, 2);
      wait_rx();
      make_rsp(hdr, st, corrupt);
      send_rsp(15);
      wait_res(50);
      check({tag, "_res_edge"}, last_res_cyc - last_rx_edge, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int base, n, rc;
      logic [3:0] pat;
      logic [7:0] str[9];
      // reset state
      repeat (3) @(negedge clk);
      check("rst_tx_valid", tx_valid, 0);
      check("rst_tx_data", tx_data, 0);
      check("rst_busy", busy, 0);
      check("rst_results", {o_pass, o_fail, o_false}, 0);
      @(posedge clk) #1;
      rst_n = 1'b1;
      // CRC engine on the standard check string
      str = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
      u_in = '0;
      for (int i = 0; i < 9; i++) begin
         u_byte = str[i];
         #1;
         u_in = u_out;
      end
      check("crc_check_string", u_in, 64'h6C40DF5F0B497347);
      // normal pass
      base = hs_edges.size();
      res_q.push_back(3'b100);
      send_cmd(56'h110100ffeaff01, 2);
      wait_rx();
      check("pass_hs_count", hs_edges.size() - base, 15);
      check("pass_latency", hs_edges[base] - acc_edge, 1);
      check("pass_hs_consecutive", hs_edges[base+14] - hs_edges[base], 14);
      make_rsp(8'h11, 8'h00, 1'b0);
      send_rsp(15);
      wait_res(50);
      check("pass_res_edge", last_res_cyc - last_rx_edge, 0);
      repeat (5) @(negedge clk);
      check("pass_one_frame", hs_edges.size() - base, 15);
      check("pass_idle", busy, 0);
      // status fail with valid_a held high through the frame
      base = hs_edges.size();
      res_q.push_back(3'b010);
      send_cmd(56'h22334455667788, 0);
      wait_rx();
      make_rsp(8'h11, 8'h03, 1'b0);
      send_rsp(15);
      wait_res(50);
      repeat (6) @(negedge clk);
      check("held_valid_no_reaccept", busy, 0);
      check("held_valid_one_frame", hs_edges.size() - base, 15);
      @(posedge clk) #1;
      valid_a = 1'b0;
      // corrupted CRC and wrong header
      run_frame(56'h0123456789abcd, 8'h11, 8'h00, 1'b1, 3'b001, "crc_err");
      run_frame(56'hfedcba98765432, 8'h12, 8'h00, 1'b0, 3'b001, "hdr_err");
      // backpressure with a 1,0,0,1 ready pattern
      pat = 4'b1001;
      res_q.push_back(3'b100);
      send_cmd(56'h5a5a5a5aa5a5a5, 2);
      n = 0;
      while (!(busy && !tx_valid) && n < 200) begin
         @(posedge clk) #1;
         tx_ready = pat[n % 4];
         n++;
      end
      tx_ready = 1'b1;
      check("bp_finished", n < 200, 1);
      make_rsp(8'h11, 8'h00, 1'b0);
      send_rsp(15);
      wait_res(50);
      // timeout with no response
      base = hs_edges.size();
      res_q.push_back(3'b001);
      send_cmd(56'h00000000000001, 2);
      wait_rx();
      wait_res(60);
      check("timeout_none_cycles", last_res_cyc - hs_edges[base+14], 16);
      // timeout after a partial response
      res_q.push_back(3'b001);
      send_cmd(56'h00000000000002, 2);
      wait_rx();
      make_rsp(8'h11, 8'h00, 1'b0);
      send_rsp(5);
      wait_res(60);
      check("timeout_partial_cycles", last_res_cyc - last_rx_edge, 16);
      // select_signal gates new commands
      base = hs_edges.size();
      @(posedge clk) #1;
      select_signal = 1'b1;
      valid_a = 1'b1;
      data_a = 56'h11111111111111;
      @(posedge clk) #1;
      valid_a = 1'b0;
      repeat (6) @(negedge clk);
      check("select_no_busy", busy, 0);
      check("select_no_tx", hs_edges.size() - base, 0);
      @(posedge clk) #1;
      select_signal = 1'b0;
      // reset 8 bytes into TX
      base = hs_edges.size();
      rc = res_cnt;
      send_cmd(56'hcafebabe123456, 2);
      n = 0;
      while (hs_edges.size() - base < 8 && n < 100) begin
         @(negedge clk) #1;
         n++;
      end
      @(posedge clk) #2;
      rst_n = 1'b0;
      #1;
      check("midrst_tx_valid", tx_valid, 0);
      check("midrst_tx_data", tx_data, 0);
      check("midrst_busy", busy, 0);
      check("midrst_results", {o_pass, o_fail, o_false}, 0);
      tx_q.delete();
      repeat (3) @(negedge clk);
      @(posedge clk) #1;
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      check("midrst_no_result", res_cnt - rc, 0);
      // fresh frame after reset starts at byte 0
      run_frame(56'h110100ffeaff01, 8'h11, 8'h00, 1'b0, 3'b100, "post_rst");
      repeat (4) @(negedge clk);
      check("tx_queue_drained", tx_q.size(), 0);
      check("res_queue_drained", res_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
